// File: rtl/hazard_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forwarding_unit
// Purpose  : Pipeline hazard unit for the ARM pipeline, upstream of the
//            control-unit mux. Tracks EX/MEM/WB destination registers in a
//            shadow pipeline and produces the ID-stage operand forwarding
//            selects, the load-use bubble/stall controls, the IF/ID flush
//            for taken branches, and saturating stall/flush event counters.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            id_*                  - ID-stage instruction description
//            cu_nop_select         - 1 = control mux emits an all-zero bubble
//            pc_load_enable,
//            ifid_load_enable      - PC and IF/ID register load enables
//            ifid_flush            - IF/ID register cleared next edge
//            fwd_a/b/c_sel         - Rn/Rm/Rd source: 00 RF, 01 EX, 10 MEM, 11 WB
//            stall_count,
//            flush_count           - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forwarding_unit #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_uses_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_branch_taken,
  output logic             cu_nop_select,
  output logic             pc_load_enable,
  output logic             ifid_load_enable,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [1:0]       fwd_c_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // The highest register specifier is the PC; it never forwards or hazards.
  localparam logic [REG_W-1:0] PC_REG  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Shadow pipeline entries (MEM/WB do not need the load flag).
  logic             ex_valid_q,  ex_valid_d;
  logic [REG_W-1:0] ex_rd_q,     ex_rd_d;
  logic             ex_rw_q,     ex_rw_d;
  logic             ex_load_q,   ex_load_d;
  logic             mem_valid_q, mem_valid_d;
  logic [REG_W-1:0] mem_rd_q,    mem_rd_d;
  logic             mem_rw_q,    mem_rw_d;
  logic             wb_valid_q,  wb_valid_d;
  logic [REG_W-1:0] wb_rd_q,     wb_rd_d;
  logic             wb_rw_q,     wb_rw_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic targets(input logic v, input logic rw,
                                   input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] r);
    return v & rw & (rd == r) & (r != PC_REG);
  endfunction

  // Per-operand hit vectors, bit 0 = EX, bit 1 = MEM, bit 2 = WB.
  logic [2:0] hit_a, hit_b, hit_c;
  assign hit_a = {targets(wb_valid_q, wb_rw_q, wb_rd_q, id_rn),
                  targets(mem_valid_q, mem_rw_q, mem_rd_q, id_rn),
                  targets(ex_valid_q, ex_rw_q, ex_rd_q, id_rn)};
  assign hit_b = {targets(wb_valid_q, wb_rw_q, wb_rd_q, id_rm),
                  targets(mem_valid_q, mem_rw_q, mem_rd_q, id_rm),
                  targets(ex_valid_q, ex_rw_q, ex_rd_q, id_rm)};
  assign hit_c = {targets(wb_valid_q, wb_rw_q, wb_rd_q, id_rd),
                  targets(mem_valid_q, mem_rw_q, mem_rd_q, id_rd),
                  targets(ex_valid_q, ex_rw_q, ex_rd_q, id_rd)};

  // Youngest producer wins: EX over MEM over WB.
  function automatic logic [1:0] pick(input logic [2:0] hit, input logic used);
    logic [1:0] sel;
    sel = 2'b00;
    if (used) begin
      if (hit[0])      sel = 2'b01;
      else if (hit[1]) sel = 2'b10;
      else if (hit[2]) sel = 2'b11;
    end
    return sel;
  endfunction

  logic load_use;
  logic stall;
  logic flush;

  always_comb begin
    load_use = id_valid & ex_load_q &
               ((id_uses_rn & hit_a[0]) |
                (id_uses_rm & hit_b[0]) |
                (id_uses_rd & hit_c[0]));
    // In HOLD the load has already moved to MEM, so a re-detected stall is spurious.
    stall = (state_q == ST_RUN) & load_use;
    flush = id_valid & id_branch_taken & ~stall;

    cu_nop_select    = stall;
    pc_load_enable   = ~stall;
    ifid_load_enable = ~stall;
    ifid_flush       = flush;
    fwd_a_sel        = pick(hit_a, id_valid & id_uses_rn);
    fwd_b_sel        = pick(hit_b, id_valid & id_uses_rm);
    fwd_c_sel        = pick(hit_c, id_valid & id_uses_rd);
    if (reset) begin
      cu_nop_select    = 1'b1;
      pc_load_enable   = 1'b0;
      ifid_load_enable = 1'b0;
      ifid_flush       = 1'b1;
      fwd_a_sel        = 2'b00;
      fwd_b_sel        = 2'b00;
      fwd_c_sel        = 2'b00;
    end

    state_d = state_q;
    case (state_q)
      ST_RUN:  if (stall) state_d = ST_HOLD;
      ST_HOLD: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    wb_valid_d  = mem_valid_q;
    wb_rd_d     = mem_rd_q;
    wb_rw_d     = mem_rw_q;
    mem_valid_d = ex_valid_q;
    mem_rd_d    = ex_rd_q;
    mem_rw_d    = ex_rw_q;
    // A stalled ID instruction is re-presented next cycle, so EX takes a bubble.
    ex_valid_d  = id_valid & ~stall;
    ex_rd_d     = id_rd;
    ex_rw_d     = id_reg_write;
    ex_load_d   = id_mem_read;

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_load_q   <= ex_load_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_rw_q    <= mem_rw_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
`default_nettype wire
